// File: rtl/wb_commit_unit.sv
// Writeback commit unit: takes the dual-lane EX/WB results, filters them,
// and retires them in program order onto one or two register-file write ports.
// Writes that cannot retire this cycle wait in a small pending FIFO. Readers
// query that FIFO through the lookup ports.
module wb_commit_unit #(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned DUAL_PORT = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        reg_write1_wb,
    input  logic        reg_write2_wb,
    input  logic [4:0]  rd1_wb,
    input  logic [4:0]  rd2_wb,
    input  logic [2:0]  au_mul_lsu1_wb,
    input  logic [2:0]  au_mul_lsu2_wb,
    input  logic [31:0] au1_wb,
    input  logic [31:0] au2_wb,
    input  logic [31:0] mul1_wb,
    input  logic [31:0] mul2_wb,
    input  logic [31:0] lsu_wb,
    output logic        rf_we1,
    output logic [4:0]  rf_waddr1,
    output logic [31:0] rf_wdata1,
    output logic        rf_we2,
    output logic [4:0]  rf_waddr2,
    output logic [31:0] rf_wdata2,
    output logic        wb_stall,
    input  logic [4:0]  lookup_addr1,
    input  logic [4:0]  lookup_addr2,
    output logic        lookup_hit1,
    output logic [31:0] lookup_data1,
    output logic        lookup_hit2,
    output logic [31:0] lookup_data2,
    output logic        sel_err,
    output logic        ovf
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned NP = (DUAL_PORT != 0) ? 2 : 1;
    localparam logic [CW-1:0] NP_C    = CW'(NP);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    // Two free entries absorb the pair already in flight when stall rises.
    localparam logic [CW-1:0] STALL_C = CW'(DEPTH - 2);

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    function automatic logic is_onehot(input logic [2:0] s);
        return (s == 3'b001) || (s == 3'b010) || (s == 3'b100);
    endfunction

    function automatic logic [31:0] pick(input logic [2:0] s, input logic [31:0] au,
                                         input logic [31:0] mul, input logic [31:0] lsu);
        case (s)
            3'b001:  return au;
            3'b010:  return mul;
            3'b100:  return lsu;
            default: return '0;
        endcase
    endfunction

    wr_t           fifo_q [DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          we1_q, we1_d, we2_q, we2_d;
    logic [4:0]    waddr1_q, waddr1_d, waddr2_q, waddr2_d;
    logic [31:0]   wdata1_q, wdata1_d, wdata2_q, wdata2_d;
    logic          stall_q, stall_d, sel_err_q, sel_err_d, ovf_q, ovf_d;

    logic          v1, v2;
    wr_t           lane1, lane2;
    wr_t           cand [4];
    logic [3:0]    cand_v;
    wr_t           e0, e1;
    logic          e0_v, e1_v;
    logic          push1, push2, push_a_en, push_b_en;
    wr_t           push_a, push_b;
    logic [CW-1:0] pop_n, free_n, want_n, acc_n;

    // Lane decode: select result, drop x0 / illegal selects, resolve same-cycle WAW.
    always_comb begin
        lane1.addr = rd1_wb;
        lane1.data = pick(au_mul_lsu1_wb, au1_wb, mul1_wb, lsu_wb);
        lane2.addr = rd2_wb;
        lane2.data = pick(au_mul_lsu2_wb, au2_wb, mul2_wb, lsu_wb);
        v1 = reg_write1_wb && (rd1_wb != 5'd0) && is_onehot(au_mul_lsu1_wb);
        v2 = reg_write2_wb && (rd2_wb != 5'd0) && is_onehot(au_mul_lsu2_wb);
        if (v1 && v2 && (rd1_wb == rd2_wb)) begin
            v1 = 1'b0;
        end
        sel_err_d = (reg_write1_wb && !is_onehot(au_mul_lsu1_wb)) ||
                    (reg_write2_wb && !is_onehot(au_mul_lsu2_wb));
    end

    // Retire selection, FIFO push/pop accounting and stall computation.
    always_comb begin
        // Only the two oldest FIFO entries can ever reach a port this cycle.
        cand[0]   = fifo_q[rd_ptr_q];
        cand_v[0] = count_q >= CW'(1);
        cand[1]   = fifo_q[rd_ptr_q + PW'(1)];
        cand_v[1] = count_q >= CW'(2);
        cand[2]   = lane1;
        cand_v[2] = v1;
        cand[3]   = lane2;
        cand_v[3] = v2;

        e0   = '0;
        e1   = '0;
        e0_v = 1'b0;
        e1_v = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (cand_v[i]) begin
                if (!e0_v) begin
                    e0   = cand[i];
                    e0_v = 1'b1;
                end else if (!e1_v) begin
                    e1   = cand[i];
                    e1_v = 1'b1;
                end
            end
        end

        we1_d    = e0_v;
        waddr1_d = e0_v ? e0.addr : 5'd0;
        wdata1_d = e0_v ? e0.data : 32'd0;
        we2_d    = 1'b0;
        waddr2_d = 5'd0;
        wdata2_d = 32'd0;
        if ((NP == 2) && e1_v) begin
            we2_d    = 1'b1;
            waddr2_d = e1.addr;
            wdata2_d = e1.data;
            // Same address on both ports: the younger write alone survives.
            if (e0.addr == e1.addr) begin
                we1_d    = 1'b0;
                waddr1_d = 5'd0;
                wdata1_d = 32'd0;
            end
        end

        pop_n = (count_q >= NP_C) ? NP_C : count_q;

        // A lane is queued when its position in the retire stream is past the ports.
        push1  = v1 && (count_q >= NP_C);
        push2  = v2 && ((count_q + CW'(v1)) >= NP_C);
        push_a = push1 ? lane1 : lane2;
        push_b = lane2;
        want_n = CW'(push1) + CW'(push2);
        free_n = DEPTH_C - count_q + pop_n;
        acc_n  = (want_n > free_n) ? free_n : want_n;
        ovf_d  = ovf_q | (want_n > free_n);

        push_a_en = acc_n >= CW'(1);
        push_b_en = acc_n >= CW'(2);

        rd_ptr_d = rd_ptr_q + PW'(pop_n);
        wr_ptr_d = wr_ptr_q + PW'(acc_n);
        count_d  = count_q - pop_n + acc_n;
        stall_d  = count_d >= STALL_C;
    end

    // Control and RF-port registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            we1_q     <= 1'b0;
            waddr1_q  <= 5'd0;
            wdata1_q  <= 32'd0;
            we2_q     <= 1'b0;
            waddr2_q  <= 5'd0;
            wdata2_q  <= 32'd0;
            stall_q   <= 1'b0;
            sel_err_q <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            we1_q     <= we1_d;
            waddr1_q  <= waddr1_d;
            wdata1_q  <= wdata1_d;
            we2_q     <= we2_d;
            waddr2_q  <= waddr2_d;
            wdata2_q  <= wdata2_d;
            stall_q   <= stall_d;
            sel_err_q <= sel_err_d;
            ovf_q     <= ovf_d;
        end
    end

    // Pending-write storage; contents are only meaningful below count_q.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (push_a_en) begin
                fifo_q[wr_ptr_q] <= push_a;
            end
            if (push_b_en) begin
                fifo_q[wr_ptr_q + PW'(1)] <= push_b;
            end
        end
    end

    logic [4:0]  la [2];
    logic        lh [2];
    logic [31:0] ld [2];

    // Lookup: later matches override earlier ones, so scan lowest priority first.
    always_comb begin
        la[0] = lookup_addr1;
        la[1] = lookup_addr2;
        for (int q = 0; q < 2; q++) begin
            lh[q] = 1'b0;
            ld[q] = 32'd0;
            if (la[q] != 5'd0) begin
                if (we1_q && (waddr1_q == la[q])) begin
                    lh[q] = 1'b1;
                    ld[q] = wdata1_q;
                end
                if (we2_q && (waddr2_q == la[q])) begin
                    lh[q] = 1'b1;
                    ld[q] = wdata2_q;
                end
                for (int i = 0; i < DEPTH; i++) begin
                    if ((CW'(i) < count_q) && (fifo_q[rd_ptr_q + PW'(i)].addr == la[q])) begin
                        lh[q] = 1'b1;
                        ld[q] = fifo_q[rd_ptr_q + PW'(i)].data;
                    end
                end
            end
        end
    end

    assign rf_we1       = we1_q;
    assign rf_waddr1    = waddr1_q;
    assign rf_wdata1    = wdata1_q;
    assign rf_we2       = we2_q;
    assign rf_waddr2    = waddr2_q;
    assign rf_wdata2    = wdata2_q;
    assign wb_stall     = stall_q;
    assign sel_err      = sel_err_q;
    assign ovf          = ovf_q;
    assign lookup_hit1  = lh[0];
    assign lookup_data1 = ld[0];
    assign lookup_hit2  = lh[1];
    assign lookup_data2 = ld[1];

endmodule
